// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file write scheduler.
//   ST_CLEAR / ST_RUN : scheduler state encoding
//   REG_DATA_W        : default register data width
//   REG_ADDR_W        : default register select width
//   REG_ZERO          : the hard-wired zero register
//   ptr_width()       : width of a requester index (at least 1 bit)
package regfile_ctrl_pkg;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the register-file write scheduler.
// The scan starts one position after the last winner and wraps.
//   req_i         : request vector
//   ptr_i         : index of the previous winner
//   grant_o       : one-hot grant (zero if nothing requests)
//   grant_idx_o   : encoded index of the winner
//   grant_valid_o : some requester won
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   grant_idx_o,
    output logic               grant_valid_o
);

    int idx;

    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = 0;
        // Offsets 1..NUM_REQ put the previous winner last in line.
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(ptr_i) + off) % NUM_REQ;
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_o[idx]  = 1'b1;
                grant_idx_o   = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Sequences the single write port of the register file among NUM_REQ
// writeback requesters, after first sweeping zeros into registers 1..N-1.
//   clock, rst       : clock and synchronous active-low reset
//   clear_req        : pulse in RUN to re-run the zero sweep
//   req_valid/sel/data : per-requester write requests (packed slices)
//   req_ready        : one-hot acceptance, combinational
//   writeSel/data/we : registered write port to the register file
//   clear_done       : high while in RUN (doubles as the state view)
// Optional feature (macro REGFILE_BYPASS_EN): read-port bypass outputs
//   rd_sel_1/2 in, byp_hit_1/2 and byp_data_1/2 out, driven from the
//   registered write stage.
// Handshake: a transfer happens in a cycle where req_valid[i] & req_ready[i];
// a requester holds sel/data stable while valid and not yet ready, and may
// drop valid at any time before it is accepted.
module regfile_write_scheduler
    import regfile_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic                      clear_req,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_sel,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         writeSel,
    output logic [DATA_W-1:0]         data,
    output logic                      we,
    output logic                      clear_done
`ifdef REGFILE_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]         rd_sel_1,
    input  logic [ADDR_W-1:0]         rd_sel_2,
    output logic                      byp_hit_1,
    output logic                      byp_hit_2,
    output logic [DATA_W-1:0]         byp_data_1,
    output logic [DATA_W-1:0]         byp_data_2
`endif
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    localparam logic [ADDR_W-1:0] LAST_REG  = '1;
    localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_INIT  = PTR_W'(NUM_REQ - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_valid;
    logic [ADDR_W-1:0]  grant_sel;
    logic [DATA_W-1:0]  grant_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i         (req_valid),
        .ptr_i         (ptr_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign grant_sel  = req_sel[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign grant_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        we_d      = 1'b0;
        sel_d     = sel_q;
        data_d    = data_q;
        req_ready = '0;
        case (state_q)
            ST_CLEAR: begin
                we_d   = 1'b1;
                sel_d  = cnt_q;
                data_d = '0;
                if (cnt_q == LAST_REG) begin
                    state_d = ST_RUN;
                    cnt_d   = FIRST_REG;
                end else begin
                    cnt_d = cnt_q + FIRST_REG;
                end
            end
            default: begin
                if (clear_req) begin
                    // Grant nothing this cycle; a write already registered
                    // is still on the outputs and completes.
                    state_d = ST_CLEAR;
                    cnt_d   = FIRST_REG;
                end else if (grant_valid) begin
                    req_ready = grant;
                    ptr_d     = grant_idx;
                    sel_d     = grant_sel;
                    data_d    = grant_data;
                    // Register 0 is hard-wired: accept but never write it.
                    we_d      = (grant_sel != '0);
                end
            end
        endcase
        if (!rst) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= FIRST_REG;
            ptr_q   <= PTR_INIT;
            we_q    <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign we         = we_q;
    assign writeSel   = sel_q;
    assign data       = data_q;
    assign clear_done = (state_q == ST_RUN);

`ifdef REGFILE_BYPASS_EN
    assign byp_hit_1  = we_q && (sel_q == rd_sel_1) && (rd_sel_1 != '0);
    assign byp_hit_2  = we_q && (sel_q == rd_sel_2) && (rd_sel_2 != '0);
    assign byp_data_1 = data_q;
    assign byp_data_2 = data_q;
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed scenarios followed by
// randomized traffic, checked against a cycle-level reference model.
module tb_regfile_write_scheduler;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              rst;
    logic              clear_req;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_sel;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [AW-1:0]     writeSel;
    logic [DW-1:0]     data;
    logic              we;
    logic              clear_done;
`ifdef REGFILE_BYPASS_EN
    logic [AW-1:0]     rd_sel_1, rd_sel_2;
    logic              byp_hit_1, byp_hit_2;
    logic [DW-1:0]     byp_data_1, byp_data_2;
`endif

    regfile_write_scheduler #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clock      (clock),
        .rst        (rst),
        .clear_req  (clear_req),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .writeSel   (writeSel),
        .data       (data),
        .we         (we),
        .clear_done (clear_done)
`ifdef REGFILE_BYPASS_EN
        ,
        .rd_sel_1   (rd_sel_1),
        .rd_sel_2   (rd_sel_2),
        .byp_hit_1  (byp_hit_1),
        .byp_hit_2  (byp_hit_2),
        .byp_data_1 (byp_data_1),
        .byp_data_2 (byp_data_2)
`endif
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: sweep position, whether the sweep is done, last
    // winner, and the write the register file should see next cycle.
    bit            m_run;
    int            m_sweep;
    int            m_last;
    logic          exp_we;
    logic [AW-1:0] exp_sel;
    logic [DW-1:0] exp_data;
    bit            sel_known;
    int            exp_gnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] s, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_sel[i*AW +: AW]  = s;
        req_data[i*DW +: DW] = d;
    endtask

    // Called just after a negedge with inputs already driven; returns at the
    // following negedge.
    task automatic tick();
        logic [N-1:0]  er;
        logic [AW-1:0] s;
        int g;
        #1;
        er = '0;
        g  = -1;
        if (rst && m_run && !clear_req) begin
            for (int off = 1; off <= N; off++) begin
                if (g < 0 && req_valid[(m_last + off) % N]) g = (m_last + off) % N;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", req_ready, er);
        if (rst) check("clear_done", clear_done, m_run);
        exp_gnt = g;

        if (!rst) begin
            m_run = 0; m_sweep = 1; m_last = N - 1;
            exp_we = 0; exp_sel = '0; exp_data = '0; sel_known = 1;
        end else if (!m_run) begin
            exp_we = 1; exp_sel = AW'(m_sweep); exp_data = '0; sel_known = 1;
            if (m_sweep == (1 << AW) - 1) begin
                m_run = 1; m_sweep = 1;
            end else begin
                m_sweep++;
            end
        end else if (clear_req) begin
            exp_we = 0; m_run = 0; m_sweep = 1;
        end else if (g >= 0) begin
            m_last    = g;
            s         = req_sel[g*AW +: AW];
            exp_we    = (s != 0);
            exp_sel   = s;
            exp_data  = req_data[g*DW +: DW];
            sel_known = (s != 0);
        end else begin
            exp_we = 0;
        end

        @(posedge clock);
        #1;
        check("we", we, exp_we);
        if (sel_known) begin
            check("writeSel", writeSel, exp_sel);
            check("data", data, exp_data);
        end
        check("reg0_write", (we && writeSel == '0), 1'b0);
`ifdef REGFILE_BYPASS_EN
        check("byp_hit_1", byp_hit_1, exp_we && exp_sel == rd_sel_1 && rd_sel_1 != '0);
        check("byp_hit_2", byp_hit_2, exp_we && exp_sel == rd_sel_2 && rd_sel_2 != '0);
        if (exp_we) begin
            check("byp_data_1", byp_data_1, exp_data);
            check("byp_data_2", byp_data_2, exp_data);
        end
`endif
        @(negedge clock);
    endtask

    initial begin
        int guard;
        rst       = 1'b0;
        clear_req = 1'b0;
        req_valid = '0;
        req_sel   = '0;
        req_data  = '0;
`ifdef REGFILE_BYPASS_EN
        rd_sel_1 = '0;
        rd_sel_2 = '0;
`endif
        m_run = 0; m_sweep = 1; m_last = N - 1;
        exp_we = 0; exp_sel = '0; exp_data = '0; sel_known = 1; exp_gnt = -1;
        @(negedge clock);

        // Reset, release, full zero sweep, then idle RUN.
        tick();
        tick();
        rst = 1'b1;
        repeat (31) tick();
        repeat (2) tick();

        // All four requesters held valid: rotating grants, one write per cycle.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'hA0 + i));
        repeat (8) tick();

        // Write aimed at register 0 is accepted but never reaches the port.
        req_valid = '0;
        set_req(2, 1'b1, '0, 32'hDEAD);
        tick();
        req_valid = '0;
        tick();

        // clear_req with a pending request: no grant, sweep, then grant.
        set_req(1, 1'b1, 5'd9, 32'h55);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (32) tick();
        req_valid = '0;
        tick();

        // Reset in the middle of a sweep restarts it from register 1.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        guard = 0;
        while (!(exp_we && exp_sel == 5'd12) && guard < 40) begin
            tick();
            guard++;
        end
        check("reach_sel12", guard < 40, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (32) tick();

`ifdef REGFILE_BYPASS_EN
        // Bypass hit on the cycle the write is presented.
        set_req(0, 1'b1, 5'd7, 32'h1234);
        rd_sel_1 = 5'd7;
        rd_sel_2 = 5'd0;
        tick();
        req_valid = '0;
        tick();
`endif

        // Randomized traffic obeying the hold-until-ready rule.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (exp_gnt == i || !req_valid[i]) begin
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
                end else if ($urandom_range(0, 9) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            clear_req = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 199) != 0);
`ifdef REGFILE_BYPASS_EN
            rd_sel_1 = AW'($urandom_range(0, 31));
            rd_sel_2 = ($urandom_range(0, 1) == 0) ? exp_sel : AW'($urandom_range(0, 31));
`endif
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
